// File: rtl/fb42_dsp_wrapper.sv
// fb42_dsp_wrapper: unsigned 9x9 multiplier slice with four precision modes.
// Mode-masked AND partial products are reduced by a Wallace or Dadda tree to
// two rows, then summed by a carry-propagate adder into a registered output.
// Optional pipeline registers split the tree layers into even segments.
module fb42_dsp_wrapper #(
  parameter int n       = 9,
  parameter int m       = 9,
  parameter int pipes   = 0,
  parameter int io_regs = 1,
  parameter int mult    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [n-1:0]     aa,
  input  logic [m-1:0]     bb,
  output logic [n+m-1:0]   out,
  output logic             compare_res
);

  localparam int W = n + m;
  // Tallest column is min(n,m); one spare row keeps every write in range.
  localparam int H = ((n < m) ? n : m) + 1;

  // Bit matrix: column i holds bits of weight 2^i, packed from row 0 upward.
  typedef logic [H-1:0]          col_t;
  typedef col_t [W-1:0]          mat_t;
  typedef logic [W-1:0][7:0]     hgt_t;

  function automatic hgt_t init_heights();
    hgt_t h;
    h = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < m; c++)
        h[r+c] = h[r+c] + 8'd1;
    return h;
  endfunction

  function automatic int max_height(input hgt_t h);
    int mx;
    mx = 0;
    for (int i = 0; i < W; i++)
      if (int'(h[i]) > mx) mx = int'(h[i]);
    return mx;
  endfunction

  // Largest member of 2,3,4,6,9,13,... strictly below the current max height.
  function automatic int dadda_target(input int mh);
    int d;
    d = 2;
    while ((d * 3) / 2 < mh) d = (d * 3) / 2;
    return d;
  endfunction

  // Full adders per column: Dadda removes only the excess over the target,
  // Wallace greedily groups every triple.
  function automatic int fa_cnt(input int h, input int cin, input int d);
    if (mult == 1) return (h + cin > d) ? (h + cin - d) / 2 : 0;
    return h / 3;
  endfunction

  function automatic int ha_cnt(input int h, input int cin, input int d);
    if (mult == 1) return (h + cin > d) ? (h + cin - d) % 2 : 0;
    return (h % 3 == 2) ? 1 : 0;
  endfunction

  function automatic hgt_t next_heights(input hgt_t h);
    hgt_t ho;
    int d, cin, hi, nf, nh;
    ho  = '0;
    cin = 0;
    d   = dadda_target(max_height(h));
    for (int i = 0; i < W; i++) begin
      hi    = int'(h[i]);
      nf    = fa_cnt(hi, cin, d);
      nh    = ha_cnt(hi, cin, d);
      ho[i] = 8'(hi - 2 * nf - nh + cin);
      cin   = nf + nh;
    end
    return ho;
  endfunction

  function automatic int num_layers();
    hgt_t h;
    int   cnt;
    h   = init_heights();
    cnt = 0;
    while (max_height(h) > 2 && cnt < 32) begin
      h   = next_heights(h);
      cnt = cnt + 1;
    end
    return cnt;
  endfunction

  function automatic hgt_t layer_heights(input int l);
    hgt_t h;
    h = init_heights();
    for (int k = 0; k < l; k++) h = next_heights(h);
    return h;
  endfunction

  localparam int NL = num_layers();

  // Mode masking is applied to each partial-product bit before reduction.
  function automatic mat_t gen_pp(input logic [n-1:0] a, input logic [m-1:0] b,
                                  input logic [1:0] md);
    mat_t mo;
    hgt_t cnt;
    logic en;
    mo  = '0;
    cnt = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < m; c++) begin
        case (md)
          2'd0:    en = (r < 5) && (c < 5);
          2'd1:    en = (r < 5);
          2'd2:    en = 1'b1;
          default: en = ((r < 4) && (c < 4)) || ((r >= 4) && (r < 8) && (c >= 4) && (c < 8));
        endcase
        mo[r+c][int'(cnt[r+c])] = a[r] & b[c] & en;
        cnt[r+c] = cnt[r+c] + 8'd1;
      end
    return mo;
  endfunction

  // One reduction layer: counters first, untouched bits next, then carries
  // arriving from the column below.
  function automatic mat_t reduce_layer(input mat_t mi, input hgt_t hi);
    mat_t mo;
    col_t car_in, car_out;
    int   d, h, cin, nf, nh, src, dst;
    logic x0, x1, x2;
    mo     = '0;
    car_in = '0;
    cin    = 0;
    d      = dadda_target(max_height(hi));
    for (int i = 0; i < W; i++) begin
      h       = int'(hi[i]);
      nf      = fa_cnt(h, cin, d);
      nh      = ha_cnt(h, cin, d);
      car_out = '0;
      src     = 0;
      dst     = 0;
      for (int k = 0; k < H; k++) begin
        if (k < nf + nh) begin
          x0 = mi[i][src];
          x1 = mi[i][src+1];
          x2 = (k < nf) ? mi[i][src+2] : 1'b0;
          mo[i][dst] = x0 ^ x1 ^ x2;
          car_out[k] = (x0 & x1) | (x0 & x2) | (x1 & x2);
          src = src + ((k < nf) ? 3 : 2);
          dst = dst + 1;
        end
      end
      for (int k = 0; k < H; k++)
        if (k >= src && k < h) begin
          mo[i][dst] = mi[i][k];
          dst = dst + 1;
        end
      for (int k = 0; k < H; k++)
        if (k < cin) begin
          mo[i][dst] = car_in[k];
          dst = dst + 1;
        end
      car_in = car_out;
      cin    = nf + nh;
    end
    return mo;
  endfunction

  function automatic mat_t run_seg(input mat_t mi, input int lo, input int hi);
    mat_t v;
    v = mi;
    for (int l = lo; l < hi; l++) v = reduce_layer(v, layer_heights(l));
    return v;
  endfunction

  // Final carry-propagate adder; the carry out of the MSB is always zero.
  function automatic logic [W-1:0] final_add(input mat_t mi);
    logic [W-1:0] r0, r1;
    for (int i = 0; i < W; i++) begin
      r0[i] = mi[i][0];
      r1[i] = mi[i][1];
    end
    return r0 + r1;
  endfunction

  logic [n-1:0] w_aa;
  logic [m-1:0] w_bb;
  logic [1:0]   w_mode;
  logic         w_vld;
  mat_t         w_seg_in  [pipes+1];
  mat_t         w_seg_out [pipes+1];
  logic         w_seg_vld [pipes+1];
  logic [W-1:0] w_sum;

  if (io_regs != 0) begin : g_in_reg
    logic [n-1:0] r_aa;
    logic [m-1:0] r_bb;
    logic [1:0]   r_mode;
    logic         r_vld;
    // Capture operands and mode only on start; the valid token follows start.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
        r_aa   <= '0;
        r_bb   <= '0;
        r_mode <= '0;
        r_vld  <= 1'b0;
      end else begin
        r_vld <= start;
        if (start) begin
          r_aa   <= aa;
          r_bb   <= bb;
          r_mode <= mode;
        end
      end
    end
    assign w_aa   = r_aa;
    assign w_bb   = r_bb;
    assign w_mode = r_mode;
    assign w_vld  = r_vld;
  end else begin : g_in_comb
    assign w_aa   = aa;
    assign w_bb   = bb;
    assign w_mode = mode;
    assign w_vld  = start;
  end

  assign w_seg_in[0]  = gen_pp(w_aa, w_bb, w_mode);
  assign w_seg_vld[0] = w_vld;

  for (genvar s = 0; s <= pipes; s++) begin : g_seg
    localparam int LO = (s * NL) / (pipes + 1);
    localparam int HI = ((s + 1) * NL) / (pipes + 1);
    assign w_seg_out[s] = run_seg(w_seg_in[s], LO, HI);
    if (s < pipes) begin : g_pipe
      mat_t r_mat;
      logic r_vld;
      // Pipeline register between tree segments; data moves only with a token.
      always_ff @(posedge clk) begin
        // NOTE: data is cleared with the valid bit so a reset leaves no stale product.
        if (rst) begin
          r_mat <= '0;
          r_vld <= 1'b0;
        end else begin
          r_vld <= w_seg_vld[s];
          if (w_seg_vld[s]) r_mat <= w_seg_out[s];
        end
      end
      assign w_seg_in[s+1]  = r_mat;
      assign w_seg_vld[s+1] = r_vld;
    end
  end

  assign w_sum = final_add(w_seg_out[pipes]);

  // Output register: loads only when a valid result exits, strobes for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      compare_res <= 1'b0;
    end else begin
      compare_res <= w_seg_vld[pipes];
      if (w_seg_vld[pipes]) out <= w_sum;
    end
  end

endmodule

// File: tb/tb_fb42_dsp_wrapper.sv
// Directed bench for fb42_dsp_wrapper: six instances covering Wallace/Dadda
// and pipes 0..2 share one stimulus stream; products come from a bench model.
module tb_fb42_dsp_wrapper;

  localparam int NI = 6;
  localparam int D  = 3;  // pipes=0, mult=1: the default configuration

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [8:0]  aa;
  logic [8:0]  bb;
  logic [17:0] o_out [NI];
  logic        o_cr  [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fb42_dsp_wrapper #(
      .n(9), .m(9), .pipes(g % 3), .io_regs(1), .mult(g / 3)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .aa(aa), .bb(bb), .out(o_out[g]), .compare_res(o_cr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [1:0] md, input logic [8:0] a,
                                           input logic [8:0] b);
    case (md)
      2'd0:    return 32'(a[4:0]) * 32'(b[4:0]);
      2'd1:    return 32'(a[4:0]) * 32'(b);
      2'd2:    return 32'(a) * 32'(b);
      default: return ((32'(a[7:4]) * 32'(b[7:4])) << 8) | (32'(a[3:0]) * 32'(b[3:0]));
    endcase
  endfunction

  task automatic drive(input logic s, input logic [1:0] md, input logic [8:0] a,
                       input logic [8:0] b);
    start = s;
    mode  = md;
    aa    = a;
    bb    = b;
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s out g%0d", tag, g), 32'(o_out[g]), 32'd0);
      check($sformatf("%s cr g%0d", tag, g), 32'(o_cr[g]), 32'd0);
    end
  endtask

  logic [1:0] s_md [200];
  logic [8:0] s_a  [200];
  logic [8:0] s_b  [200];

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    drive(1'b1, 2'd2, 9'h1FF, 9'h1FF);
    #2;
    // Reset held two edges with start high: everything stays zero.
    tick(); check_all_zero("rst1");
    tick(); check_all_zero("rst2");
    rst = 1'b0;
    drive(1'b0, 2'd0, 9'h000, 9'h000);
    tick(); check_all_zero("rst_release");
    repeat (4) tick();

    // Mode 0: upper bits are masked off.
    drive(1'b1, 2'd0, 9'h1F3, 9'h1EB); tick();
    drive(1'b0, 2'd0, 9'h000, 9'h000); tick();
    check("m0 cr", 32'(o_cr[D]), 32'd1);
    check("m0 out", 32'(o_out[D]), 32'd209);
    drive(1'b1, 2'd0, 9'h013, 9'h00B); tick();
    drive(1'b0, 2'd0, 9'h000, 9'h000); tick();
    check("m0 low-only out", 32'(o_out[D]), 32'd209);

    // Mode 1 then an idle slot: out holds.
    drive(1'b1, 2'd1, 9'd31, 9'd511); tick();
    drive(1'b0, 2'd2, 9'h1FF, 9'h1FF); tick();
    check("m1 cr", 32'(o_cr[D]), 32'd1);
    check("m1 out", 32'(o_out[D]), 32'd15841);
    tick();
    check("idle cr", 32'(o_cr[D]), 32'd0);
    check("idle hold", 32'(o_out[D]), 32'd15841);

    // Mode 2 full precision.
    drive(1'b1, 2'd2, 9'd511, 9'd511); tick();
    drive(1'b0, 2'd0, 9'h000, 9'h000); tick();
    check("m2 out", 32'(o_out[D]), 32'd261121);

    // Mode 3 dual 4x4 with cross products suppressed.
    drive(1'b1, 2'd3, 9'h0A3, 9'h0C5); tick();
    drive(1'b0, 2'd0, 9'h000, 9'h000); tick();
    r = 32'(o_out[D]);
    check("m3 lo", {24'd0, r[7:0]}, 32'd15);
    check("m3 hi", {24'd0, r[15:8]}, 32'd120);
    check("m3 top", {30'd0, r[17:16]}, 32'd0);

    // Back-to-back with a mode change: each result keeps its own mode.
    drive(1'b1, 2'd2, 9'h1FF, 9'h1FF); tick();
    drive(1'b1, 2'd0, 9'h1FF, 9'h1FF); tick();
    check("b2b m2 out", 32'(o_out[D]), 32'd261121);
    drive(1'b0, 2'd0, 9'h000, 9'h000); tick();
    check("b2b m0 cr", 32'(o_cr[D]), 32'd1);
    check("b2b m0 out", 32'(o_out[D]), 32'd961);
    repeat (4) tick();

    // Streaming: 200 consecutive operations into every configuration.
    for (int i = 0; i < 200; i++) begin
      s_md[i] = (i < 100) ? 2'd0 : 2'($urandom_range(0, 3));
      s_a[i]  = 9'($urandom_range(0, 511));
      s_b[i]  = 9'($urandom_range(0, 511));
    end
    for (int j = 0; j < 204; j++) begin
      if (j < 200) drive(1'b1, s_md[j], s_a[j], s_b[j]);
      else         drive(1'b0, 2'd0, 9'h000, 9'h000);
      tick();
      for (int g = 0; g < NI; g++) begin
        int k;
        k = j - 1 - (g % 3);
        if (k >= 0 && k < 200) begin
          check($sformatf("stream cr g%0d j%0d", g, j), 32'(o_cr[g]), 32'd1);
          check($sformatf("stream out g%0d j%0d", g, j), 32'(o_out[g]),
                ref_prod(s_md[k], s_a[k], s_b[k]));
        end else begin
          check($sformatf("stream idle cr g%0d j%0d", g, j), 32'(o_cr[g]), 32'd0);
        end
      end
    end
    repeat (2) tick();

    // Reset while two operations are in flight: no strobe, out cleared.
    drive(1'b1, 2'd2, 9'd300, 9'd200); tick();
    drive(1'b1, 2'd2, 9'd400, 9'd100); tick();
    rst = 1'b1;
    drive(1'b1, 2'd2, 9'd7, 9'd7); tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 9'h000, 9'h000);
    for (int c = 0; c < 4; c++) begin
      check_all_zero($sformatf("midrst c%0d", c));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
